laser_vout_rd_engine: RTL and testbench

Parametrised DDR read-back engine for the laser output path, operating in the DDR clock domain. It issues burst reads whenever the writer is ahead (burst line counters) and the local buffer has room for a full burst. It buffers returned MEM words in an internal synchronous FIFO and unpacks them LSB-first into OUT_WIDTH beats on a valid/ready stream. It supports a ring-address mode and a single-frame mode, flushes cleanly on start/stop, and feeds the existing async FIFO / laser consumer.

---
 rtl/laser_vout_pkg.sv | 33 +++
 rtl/mem_vout_sync_fifo.sv | 78 +++++++
 rtl/laser_vout_rd_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_laser_vout_rd_engine.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_vout_pkg.sv
// Shared types and helpers for the laser output DDR read-back engine.
package laser_vout_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StReq,
        StData,
        StFlush
    } rd_state_e;

    function automatic int unsigned calc_ratio(input int unsigned mem_bits,
                                               input int unsigned out_bits);
        return mem_bits / out_bits;
    endfunction

    function automatic int unsigned idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // DDR address of a burst line, folded into the ring.
    function automatic longint unsigned ring_addr(input longint unsigned base,
                                                  input longint unsigned inc,
                                                  input longint unsigned ring,
                                                  input longint unsigned line);
        return base + (line % ring) * inc;
    endfunction

endpackage

// File: rtl/mem_vout_sync_fifo.sv
// Single-clock word FIFO with a registered head word, occupancy count and flush.
module mem_vout_sync_fifo
    import laser_vout_pkg::*;
#(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 512
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   rd_valid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             w_wr;
    logic             w_rd;
    logic [AW-1:0]    w_rd_ptr_nxt;

    assign full_o       = (r_level == LW'(DEPTH));
    assign w_wr         = wr_en_i & ~full_o;
    assign w_rd         = rd_en_i & (r_level != '0);
    assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    assign rd_data_o    = r_dout;
    assign rd_valid_o   = (r_level != '0);
    assign level_o      = r_level;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data_i;
        end
    end

    // The head word counts toward the level; it is refilled on pop so the
    // consumer sees back-to-back words, bypassing the array when it is empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
            if (w_rd) begin
                if (r_level >= LW'(2)) begin
                    r_dout <= r_mem[w_rd_ptr_nxt];
                end else if (w_wr) begin
                    r_dout <= wr_data_i;
                end
            end else if ((r_level == '0) && w_wr) begin
                r_dout <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/laser_vout_rd_engine.sv
// DDR read-back engine: issues burst reads while the writer is ahead, buffers
// returned words and unpacks them LSB-first onto a valid/ready beat stream.
module laser_vout_rd_engine
    import laser_vout_pkg::*;
#(
    parameter int unsigned     ADDR_WIDTH    = 30,
    parameter int unsigned     MEM_DATA_BITS = 256,
    parameter int unsigned     OUT_WIDTH     = 64,
    parameter int unsigned     BURST_LEN     = 128,
    parameter int unsigned     FIFO_DEPTH    = 512,
    parameter int unsigned     LINE_WIDTH    = 18,
    parameter longint unsigned BASE_ADDR     = 0,
    parameter longint unsigned ADDR_INC      = 1024,
    parameter longint unsigned RING_LINES    = 2 ** 18
) (
    input  logic                        ddr_clk_i,
    input  logic                        ddr_rst_n_i,
    input  logic                        laser_start_i,
    input  logic                        frame_mode_i,
    input  logic [LINE_WIDTH-1:0]       frame_lines_i,
    input  logic [LINE_WIDTH-1:0]       wr_burst_line_i,
    output logic [LINE_WIDTH-1:0]       rd_burst_line_o,
    output logic                        rd_ddr_req_o,
    output logic [7:0]                  rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]       rd_ddr_addr_o,
    input  logic                        rd_ddr_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0]    rd_ddr_data_i,
    input  logic                        rd_ddr_finish_i,
    output logic                        vout_valid_o,
    output logic [OUT_WIDTH-1:0]        vout_data_o,
    input  logic                        vout_ready_i,
    output logic                        frame_done_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        err_ovf_o
);

    localparam int unsigned RATIO = calc_ratio(MEM_DATA_BITS, OUT_WIDTH);
    localparam int unsigned IDXW  = idx_width(RATIO);
    localparam int unsigned LVLW  = level_width(FIFO_DEPTH);

    rd_state_e              r_state;
    rd_state_e              w_state_nxt;
    logic                   r_start_d;
    logic [LINE_WIDTH-1:0]  r_rd_line;
    logic [LINE_WIDTH-1:0]  r_frame_lines;
    logic                   r_frame_done;
    logic                   r_restart_pend;
    logic                   r_err_ovf;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [7:0]             r_len;
    logic [IDXW-1:0]        r_idx;

    logic                   w_start_rise;
    logic                   w_start_fall;
    logic                   w_flush;
    logic                   w_restart;
    logic                   w_line_inc;
    logic                   w_done_set;
    logic                   w_load_addr;
    logic                   w_ahead;
    logic                   w_room;
    logic [LINE_WIDTH-1:0]  w_line_nxt;
    logic                   w_fifo_wr;
    logic                   w_fifo_full;
    logic                   w_fifo_ovf;
    logic                   w_head_valid;
    logic [MEM_DATA_BITS-1:0] w_head;
    logic [LVLW-1:0]        w_level;
    logic                   w_accept;
    logic                   w_last_beat;
    logic                   w_pop;

    assign w_start_rise = laser_start_i & ~r_start_d;
    assign w_start_fall = ~laser_start_i & r_start_d;
    assign w_ahead      = ((wr_burst_line_i - r_rd_line) != '0);
    assign w_room       = ((LVLW'(FIFO_DEPTH) - w_level) >= LVLW'(BURST_LEN));
    assign w_line_nxt   = r_rd_line + LINE_WIDTH'(1);
    assign w_fifo_wr    = (r_state == StData) & rd_ddr_data_valid_i;
    assign w_fifo_ovf   = w_fifo_wr & w_fifo_full;
    assign w_accept     = w_head_valid & vout_ready_i;
    assign w_last_beat  = (r_idx == IDXW'(RATIO - 1));
    assign w_pop        = w_accept & w_last_beat;

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_restart   = 1'b0;
        w_line_inc  = 1'b0;
        w_done_set  = 1'b0;
        w_load_addr = 1'b0;
        if (w_start_rise && (r_state != StFlush)) begin
            w_restart   = 1'b1;
            w_flush     = 1'b1;
            w_state_nxt = StArm;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_flush = w_start_fall;
                end
                StArm: begin
                    if (w_start_fall) begin
                        w_flush     = 1'b1;
                        w_state_nxt = StIdle;
                    end else if (laser_start_i && w_ahead && w_room && !r_frame_done) begin
                        w_load_addr = 1'b1;
                        w_state_nxt = StReq;
                    end
                end
                StReq: begin
                    w_state_nxt = w_start_fall ? StFlush : StData;
                end
                StData: begin
                    if (rd_ddr_finish_i) begin
                        if (w_start_fall) begin
                            w_flush     = 1'b1;
                            w_state_nxt = StIdle;
                        end else begin
                            w_line_inc = 1'b1;
                            if (frame_mode_i && (w_line_nxt == r_frame_lines)) begin
                                w_done_set  = 1'b1;
                                w_state_nxt = StIdle;
                            end else begin
                                w_state_nxt = StArm;
                            end
                        end
                    end else if (w_start_fall) begin
                        w_state_nxt = StFlush;
                    end
                end
                StFlush: begin
                    // A restart requested while the aborted burst drains runs after finish.
                    if (rd_ddr_finish_i) begin
                        w_flush = 1'b1;
                        if ((r_restart_pend && !w_start_fall) || w_start_rise) begin
                            w_restart   = 1'b1;
                            w_state_nxt = StArm;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    // Edge detector resets high so a start held through reset is not a new start.
    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            r_state        <= StIdle;
            r_start_d      <= 1'b1;
            r_rd_line      <= '0;
            r_frame_lines  <= '0;
            r_frame_done   <= 1'b0;
            r_restart_pend <= 1'b0;
            r_err_ovf      <= 1'b0;
            r_addr         <= '0;
            r_len          <= '0;
            r_idx          <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= laser_start_i;
            if (w_start_rise) begin
                r_frame_lines <= frame_lines_i;
            end
            if (w_restart) begin
                r_rd_line    <= '0;
                r_frame_done <= 1'b0;
            end else begin
                if (w_line_inc) begin
                    r_rd_line <= w_line_nxt;
                end
                if (w_done_set) begin
                    r_frame_done <= 1'b1;
                end
            end
            if (r_state == StFlush) begin
                if (w_start_rise) begin
                    r_restart_pend <= 1'b1;
                end else if (w_start_fall) begin
                    r_restart_pend <= 1'b0;
                end
            end else begin
                r_restart_pend <= 1'b0;
            end
            if (w_fifo_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_load_addr) begin
                r_addr <= ADDR_WIDTH'(ring_addr(BASE_ADDR, ADDR_INC, RING_LINES,
                                                64'(r_rd_line)));
                r_len  <= 8'(BURST_LEN);
            end
            if (w_flush) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= w_last_beat ? '0 : r_idx + IDXW'(1);
            end
        end
    end

    mem_vout_sync_fifo #(
        .WIDTH (MEM_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (ddr_clk_i),
        .rst_n_i    (ddr_rst_n_i),
        .flush_i    (w_flush),
        .wr_en_i    (w_fifo_wr),
        .wr_data_i  (rd_ddr_data_i),
        .rd_en_i    (w_pop),
        .rd_data_o  (w_head),
        .rd_valid_o (w_head_valid),
        .level_o    (w_level),
        .full_o     (w_fifo_full)
    );

    assign rd_burst_line_o = r_rd_line;
    assign rd_ddr_req_o    = (r_state == StReq);
    assign rd_ddr_len_o    = r_len;
    assign rd_ddr_addr_o   = r_addr;
    assign vout_valid_o    = w_head_valid;
    assign vout_data_o     = w_head[int'(r_idx) * OUT_WIDTH +: OUT_WIDTH];
    assign frame_done_o    = r_frame_done;
    assign fifo_level_o    = w_level;
    assign err_ovf_o       = r_err_ovf;

endmodule

// File: tb/tb_laser_vout_rd_engine.sv
// Directed bench for laser_vout_rd_engine with a behavioural DDR responder and beat monitor.
module tb_laser_vout_rd_engine;

    localparam int unsigned     AW    = 30;
    localparam int unsigned     MW    = 256;
    localparam int unsigned     OW    = 64;
    localparam int unsigned     BL    = 128;
    localparam int unsigned     FD    = 512;
    localparam int unsigned     LW    = 3;
    localparam longint unsigned BASE  = 64'h10_0000;
    localparam longint unsigned INC   = 1024;
    localparam longint unsigned RING  = 4;
    localparam int unsigned     BEATS = MW / OW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              fmode = 1'b0;
    logic [LW-1:0]     flines = '0;
    logic [LW-1:0]     wr_line = '0;
    logic              dv = 1'b0;
    logic [MW-1:0]     dat = '0;
    logic              fin = 1'b0;
    logic              ready = 1'b0;

    logic [LW-1:0]     rd_line;
    logic              req;
    logic [7:0]        len;
    logic [AW-1:0]     addr;
    logic              vout_valid;
    logic [OW-1:0]     vout_data;
    logic              frame_done;
    logic [$clog2(FD):0] level;
    logic              err_ovf;

    int errors = 0;
    int checks = 0;
    int req_count = 0;
    logic [AW-1:0] req_addr [0:255];
    logic [7:0]    req_len  [0:255];
    int   resp_word = 0;
    logic resp_busy = 1'b0;
    int   beat_count = 0;
    int   beat_base = 0;
    int   beat_bad = 0;
    int   bad_idx = 0;
    logic chk_beats = 1'b0;
    logic [OW-1:0] bad_got = '0;
    logic [OW-1:0] bad_exp = '0;
    int   rbase;

    laser_vout_rd_engine #(
        .ADDR_WIDTH    (AW),
        .MEM_DATA_BITS (MW),
        .OUT_WIDTH     (OW),
        .BURST_LEN     (BL),
        .FIFO_DEPTH    (FD),
        .LINE_WIDTH    (LW),
        .BASE_ADDR     (BASE),
        .ADDR_INC      (INC),
        .RING_LINES    (RING)
    ) dut (
        .ddr_clk_i           (clk),
        .ddr_rst_n_i         (rst_n),
        .laser_start_i       (start),
        .frame_mode_i        (fmode),
        .frame_lines_i       (flines),
        .wr_burst_line_i     (wr_line),
        .rd_burst_line_o     (rd_line),
        .rd_ddr_req_o        (req),
        .rd_ddr_len_o        (len),
        .rd_ddr_addr_o       (addr),
        .rd_ddr_data_valid_i (dv),
        .rd_ddr_data_i       (dat),
        .rd_ddr_finish_i     (fin),
        .vout_valid_o        (vout_valid),
        .vout_data_o         (vout_data),
        .vout_ready_i        (ready),
        .frame_done_o        (frame_done),
        .fifo_level_o        (level),
        .err_ovf_o           (err_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] gen_word(input logic [AW-1:0] a, input int w);
        logic [MW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(BEATS); k++) begin
            r[k*OW +: OW] = {8'(k), 8'hC3, 16'(w), 32'(a)};
        end
        return r;
    endfunction

    // DDR model: two cycles after a request, BL words back to back, then finish.
    initial begin : ddr_model
        logic [AW-1:0] cap;
        forever begin
            @(negedge clk);
            if (req === 1'b1) begin
                cap = addr;
                req_addr[req_count] = addr;
                req_len[req_count]  = len;
                req_count++;
                resp_busy = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #1;
                for (int w = 0; w < int'(BL); w++) begin
                    dat = gen_word(cap, w);
                    dv = 1'b1;
                    resp_word = w + 1;
                    @(posedge clk);
                    #1;
                end
                dv = 1'b0;
                fin = 1'b1;
                @(posedge clk);
                #1;
                fin = 1'b0;
                resp_busy = 1'b0;
                resp_word = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (vout_valid && ready) begin
            if (chk_beats) begin
                int idx, b, rem, w, k;
                logic [OW-1:0] e;
                idx = beat_count - beat_base;
                b   = idx / int'(BL * BEATS);
                rem = idx % int'(BL * BEATS);
                w   = rem / int'(BEATS);
                k   = rem % int'(BEATS);
                e   = {8'(k), 8'hC3, 16'(w), 32'(BASE + longint'(b) * INC)};
                if (vout_data !== e) begin
                    if (beat_bad == 0) begin
                        bad_idx = idx;
                        bad_got = vout_data;
                        bad_exp = e;
                    end
                    beat_bad++;
                end
            end
            beat_count++;
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        wait_cycles(4);
        rst_n = 1'b1;
        wait_cycles(2);
        checks++;
        if ({req, vout_valid, frame_done, err_ovf} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {req, vout_valid, frame_done, err_ovf});
        end
        checks++;
        if ({len, addr} !== '0) begin
            errors++;
            $display("FAIL reset_len_addr: got len=%0d addr=%h expected 0", len, addr);
        end
        checks++;
        if (level !== '0 || rd_line !== '0 || vout_data !== '0) begin
            errors++;
            $display("FAIL reset_level_line_data: got %0d %0d %h expected 0", level, rd_line, vout_data);
        end
    endtask

    task automatic test_basic();
        ready = 1'b1;
        fmode = 1'b0;
        wr_line = 3'd3;
        beat_base = beat_count;
        chk_beats = 1'b1;
        rbase = req_count;
        start = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ((beat_count - beat_base) >= int'(3 * BL * BEATS) && !resp_busy) break;
            @(negedge clk);
        end
        chk_beats = 1'b0;
        checks++;
        if (beat_count - beat_base != int'(3 * BL * BEATS)) begin
            errors++;
            $display("FAIL basic_beats: got %0d expected %0d", beat_count - beat_base, 3 * BL * BEATS);
        end
        checks++;
        if (beat_bad != 0) begin
            errors++;
            $display("FAIL basic_beat_order: %0d bad, first idx %0d got %h expected %h",
                     beat_bad, bad_idx, bad_got, bad_exp);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_addr[rbase+i] !== AW'(BASE + longint'(i) * INC) || req_len[rbase+i] !== 8'd128) begin
                errors++;
                $display("FAIL basic_req%0d: got addr=%h len=%0d expected addr=%h len=128",
                         i, req_addr[rbase+i], req_len[rbase+i], AW'(BASE + longint'(i) * INC));
            end
        end
        wait_cycles(100);
        checks++;
        if (req_count - rbase != 3 || rd_line !== 3'd3) begin
            errors++;
            $display("FAIL basic_req_count: got reqs=%0d rd_line=%0d expected 3 and 3",
                     req_count - rbase, rd_line);
        end
        start = 1'b0;
        wait_cycles(5);
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        wr_line = 3'd7;
        rbase = req_count;
        start = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (req_count - rbase >= 4 && !resp_busy) break;
            @(negedge clk);
        end
        wait_cycles(100);
        checks++;
        if (req_count - rbase != 4) begin
            errors++;
            $display("FAIL bp_req_count: got %0d expected 4", req_count - rbase);
        end
        checks++;
        if (level !== 10'd512 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_level: got level=%0d ovf=%b expected 512 and 0", level, err_ovf);
        end
        checks++;
        if (vout_valid !== 1'b1 || vout_data !== {8'd0, 8'hC3, 16'd0, 32'(BASE)}) begin
            errors++;
            $display("FAIL bp_hold: got valid=%b data=%h expected 1 and %h",
                     vout_valid, vout_data, {8'd0, 8'hC3, 16'd0, 32'(BASE)});
        end
        ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (req_count - rbase >= 5) break;
            @(negedge clk);
        end
        checks++;
        if (req_count - rbase != 5 || req_addr[rbase+4] !== AW'(BASE)) begin
            errors++;
            $display("FAIL bp_resume_ring: got reqs=%0d addr=%h expected 5 and %h",
                     req_count - rbase, req_addr[rbase+4], AW'(BASE));
        end
        for (int i = 0; i < 20000; i++) begin
            if (rd_line == 3'd7 && !resp_busy) break;
            @(negedge clk);
        end
        start = 1'b0;
        wait_cycles(5);
        checks++;
        if (vout_valid !== 1'b0 || level !== '0 || rd_line !== 3'd7) begin
            errors++;
            $display("FAIL bp_stop_flush: got valid=%b level=%0d rd_line=%0d expected 0 0 7",
                     vout_valid, level, rd_line);
        end
    endtask

    task automatic test_frame();
        fmode = 1'b1;
        flines = 3'd2;
        rbase = req_count;
        start = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (frame_done === 1'b1) break;
            @(negedge clk);
        end
        wait_cycles(300);
        checks++;
        if (frame_done !== 1'b1 || rd_line !== 3'd2) begin
            errors++;
            $display("FAIL frame_done: got done=%b rd_line=%0d expected 1 and 2", frame_done, rd_line);
        end
        checks++;
        if (req_count - rbase != 2) begin
            errors++;
            $display("FAIL frame_req_count: got %0d expected 2", req_count - rbase);
        end
        start = 1'b0;
        fmode = 1'b0;
        wait_cycles(5);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_hold: got %b expected 1", frame_done);
        end
    endtask

    task automatic test_abort();
        rbase = req_count;
        start = 1'b1;
        wait_cycles(2);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_clear: got %b expected 0", frame_done);
        end
        for (int i = 0; i < 2000; i++) begin
            if (resp_busy && resp_word >= 40) break;
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!resp_busy) break;
            @(negedge clk);
        end
        wait_cycles(3);
        checks++;
        if (rd_line !== 3'd0 || vout_valid !== 1'b0 || level !== '0 || req_count - rbase != 1) begin
            errors++;
            $display("FAIL abort_state: got rd_line=%0d valid=%b level=%0d reqs=%0d expected 0 0 0 1",
                     rd_line, vout_valid, level, req_count - rbase);
        end
        rbase = req_count;
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_count - rbase >= 1) break;
            @(negedge clk);
        end
        checks++;
        if (req_count - rbase != 1 || req_addr[rbase] !== AW'(BASE) || rd_line !== 3'd0) begin
            errors++;
            $display("FAIL abort_restart: got reqs=%0d addr=%h rd_line=%0d expected 1 %h 0",
                     req_count - rbase, req_addr[rbase], rd_line, AW'(BASE));
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20000; i++) begin
            if (rd_line == 3'd7 && !resp_busy) break;
            @(negedge clk);
        end
        checks++;
        if (rd_line !== 3'd7) begin
            errors++;
            $display("FAIL wrap_reach7: got %0d expected 7", rd_line);
        end
        rbase = req_count;
        wr_line = 3'd0;
        for (int i = 0; i < 2000; i++) begin
            if (rd_line == 3'd0) break;
            @(negedge clk);
        end
        wait_cycles(200);
        checks++;
        if (rd_line !== 3'd0 || req_count - rbase != 1) begin
            errors++;
            $display("FAIL wrap_count: got rd_line=%0d reqs=%0d expected 0 and 1", rd_line, req_count - rbase);
        end
        checks++;
        if (req_addr[rbase] !== AW'(BASE + 3 * INC)) begin
            errors++;
            $display("FAIL wrap_addr: got %h expected %h", req_addr[rbase], AW'(BASE + 3 * INC));
        end
    endtask

    task automatic test_async_reset();
        wr_line = 3'd3;
        for (int i = 0; i < 2000; i++) begin
            if (resp_busy && resp_word >= 20) break;
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req, vout_valid, frame_done, err_ovf} !== 4'b0 || {len, addr} !== '0) begin
            errors++;
            $display("FAIL arst_ctrl: got flags=%b len=%0d addr=%h expected 0",
                     {req, vout_valid, frame_done, err_ovf}, len, addr);
        end
        checks++;
        if (level !== '0 || rd_line !== '0 || vout_data !== '0) begin
            errors++;
            $display("FAIL arst_data: got level=%0d rd_line=%0d data=%h expected 0", level, rd_line, vout_data);
        end
        wait_cycles(3);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (!resp_busy) break;
            @(negedge clk);
        end
        rbase = req_count;
        wait_cycles(200);
        checks++;
        if (req_count != rbase) begin
            errors++;
            $display("FAIL arst_no_req: got %0d expected 0", req_count - rbase);
        end
        start = 1'b0;
        wait_cycles(3);
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_count - rbase >= 1) break;
            @(negedge clk);
        end
        checks++;
        if (req_count - rbase != 1 || req_addr[rbase] !== AW'(BASE)) begin
            errors++;
            $display("FAIL arst_restart: got reqs=%0d addr=%h expected 1 %h",
                     req_count - rbase, req_addr[rbase], AW'(BASE));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_frame();
        test_abort();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
